// File: rtl/hpdmc_ddr_wrpath_if.sv
// hpdmc_ddr_wrpath_if: scheduler/FIFO/PHY-side signals of the DDR write datapath
interface hpdmc_ddr_wrpath_if #(parameter int DQ_WIDTH = 16);
  logic write, wr_ready, di_valid, di_ack, dq_oe, dqs_oe, clear_err, underrun, proto_err;
  logic [2*DQ_WIDTH-1:0] di;
  logic [DQ_WIDTH/4-1:0] dmi;
  logic [DQ_WIDTH-1:0] dq_q0, dq_q1;
  logic [DQ_WIDTH/8-1:0] dm_q0, dm_q1, dqs_q0, dqs_q1;
  modport master(
    output write, di, dmi, di_valid, clear_err,
    input wr_ready, di_ack, dq_q0, dq_q1, dm_q0, dm_q1, dqs_q0, dqs_q1, dq_oe, dqs_oe, underrun, proto_err
  );
  modport slave(
    input write, di, dmi, di_valid, clear_err,
    output wr_ready, di_ack, dq_q0, dq_q1, dm_q0, dm_q1, dqs_q0, dqs_q1, dq_oe, dqs_oe, underrun, proto_err
  );
endinterface

// File: rtl/hpdmc_ddr_wrpath.sv
// hpdmc_ddr_wrpath: DDR write path generating DQS/DQ enables and per-beat data/mask for output DDR registers
module hpdmc_ddr_wrpath #(
  parameter int DQ_WIDTH = 16,
  parameter int BURST_BEATS = 4,
  parameter int WRITE_LATENCY = 1
) (
  input logic sys_clk,
  input logic sys_rst,
  hpdmc_ddr_wrpath_if.slave bus
);
  localparam int NB = DQ_WIDTH/8;
  localparam int WW = $clog2(WRITE_LATENCY+1);
  localparam int BW = $clog2(BURST_BEATS+1);
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, PREAMBLE = 3'd2, DATA = 3'd3, POSTAMBLE = 3'd4;
  localparam logic [2:0] GO = WRITE_LATENCY > 1 ? WAIT : PREAMBLE;
  localparam logic [WW-1:0] WL_LOAD = WW'(WRITE_LATENCY-1);
  localparam logic [BW-1:0] LAST = BW'(BURST_BEATS-1);
  logic [2:0] state, nxt;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic start, load_en;
  assign bus.wr_ready = state == IDLE || state == POSTAMBLE;
  assign start = bus.write & bus.wr_ready;
  always_comb begin
    nxt = (state == IDLE || state == POSTAMBLE) ? (start ? GO : IDLE)
        : state == WAIT ? (wcnt == WW'(1) ? PREAMBLE : WAIT)
        : state == PREAMBLE ? DATA
        : state == DATA ? (bcnt == LAST ? POSTAMBLE : DATA)
        : IDLE;
  end
  // A beat is fetched in the cycle before it is driven, so loading keys off the next state
  assign load_en = nxt == DATA;
  assign bus.di_ack = load_en & bus.di_valid;
  assign bus.dqs_q1 = '0;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      wcnt <= '0;
      bcnt <= '0;
      bus.dqs_oe <= 1'b0;
      bus.dq_oe <= 1'b0;
      bus.dqs_q0 <= '0;
      bus.dq_q0 <= '0;
      bus.dq_q1 <= '0;
      bus.dm_q0 <= '0;
      bus.dm_q1 <= '0;
      bus.underrun <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      state <= nxt;
      wcnt <= state == WAIT ? wcnt - 1'b1 : WL_LOAD;
      bcnt <= state == DATA ? bcnt + 1'b1 : '0;
      bus.dqs_oe <= nxt != IDLE && nxt != WAIT;
      bus.dq_oe <= load_en;
      bus.dqs_q0 <= {NB{load_en}};
      bus.dq_q0 <= bus.di_ack ? bus.di[2*DQ_WIDTH-1:DQ_WIDTH] : '0;
      bus.dq_q1 <= bus.di_ack ? bus.di[DQ_WIDTH-1:0] : '0;
      // Underrun keeps burst timing and masks every byte of the missing beat
      bus.dm_q0 <= load_en ? (bus.di_valid ? bus.dmi[2*NB-1:NB] : '1) : '0;
      bus.dm_q1 <= load_en ? (bus.di_valid ? bus.dmi[NB-1:0] : '1) : '0;
      bus.underrun <= (load_en & ~bus.di_valid) | (bus.underrun & ~bus.clear_err);
      bus.proto_err <= (bus.write & ~bus.wr_ready) | (bus.proto_err & ~bus.clear_err);
    end
  end
endmodule

// File: tb/tb_hpdmc_ddr_wrpath.sv
// tb_hpdmc_ddr_wrpath: randomized scoreboard bench over two latency/burst configurations
module tb_hpdmc_ddr_wrpath;
  localparam int DW = 16;
  localparam int NB = DW/8;
  localparam int CYCLES = 1500;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  logic [1:0] done = 2'b00;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int WL = g ? 3 : 1;
    localparam int BB = g ? 2 : 4;
    logic rst;
    hpdmc_ddr_wrpath_if #(.DQ_WIDTH(DW)) bus();
    hpdmc_ddr_wrpath #(.DQ_WIDTH(DW), .BURST_BEATS(BB), .WRITE_LATENCY(WL)) dut (
      .sys_clk(clk),
      .sys_rst(rst),
      .bus(bus.slave)
    );
    logic [2*DW+DW/4-1:0] beats[$];
    logic [3:0] ctls[$];
    initial begin
      int start, k, k1;
      logic und, pe, ready, load, dqs_oe, dq_oe;
      start = -1000;
      und = 1'b0;
      pe = 1'b0;
      rst = 1'b1;
      bus.write = 1'b0;
      bus.di = '0;
      bus.dmi = '0;
      bus.di_valid = 1'b0;
      bus.clear_err = 1'b0;
      @(posedge clk);
      #1;
      ctls.push_back(4'b0000);
      for (int c = 0; c < CYCLES; c++) begin
        rst = $urandom_range(79) == 0;
        bus.write = c < CYCLES - 20 && $urandom_range(2) == 0;
        bus.di = {$urandom, $urandom};
        bus.dmi = 4'($urandom);
        bus.di_valid = $urandom_range(4) != 0;
        bus.clear_err = $urandom_range(9) == 0;
        #1;
        k = c - start;
        ready = !(k >= 1 && k <= WL + BB);
        load = k >= WL && k <= WL + BB - 1;
        chk("wr_ready", 64'(bus.wr_ready), 64'(ready));
        chk("di_ack", 64'(bus.di_ack), 64'(load && bus.di_valid));
        if (rst) begin
          start = -1000;
          und = 1'b0;
          pe = 1'b0;
          ctls.push_back(4'b0000);
        end else begin
          if (bus.write && ready) start = c;
          pe = (bus.write && !ready) | (pe & !bus.clear_err);
          und = (load && !bus.di_valid) | (und & !bus.clear_err);
          if (load) beats.push_back(bus.di_valid ? {bus.di, bus.dmi} : {{(2*DW){1'b0}}, {(DW/4){1'b1}}});
          k1 = c + 1 - start;
          dqs_oe = k1 >= WL && k1 <= WL + BB + 1;
          dq_oe = k1 >= WL + 1 && k1 <= WL + BB;
          ctls.push_back({dqs_oe, dq_oe, und, pe});
        end
        @(posedge clk);
        #1;
      end
      rst = 1'b0;
      bus.write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("beats_drained", 64'(beats.size()), 64'd0);
      done[g] = 1'b1;
    end
    initial forever begin
      logic [3:0] e;
      logic [2*DW+DW/4-1:0] b;
      @(negedge clk);
      if (ctls.size() > 0 && !done[g]) begin
        e = ctls.pop_front();
        chk("dqs_oe", 64'(bus.dqs_oe), 64'(e[3]));
        chk("dq_oe", 64'(bus.dq_oe), 64'(e[2]));
        chk("underrun", 64'(bus.underrun), 64'(e[1]));
        chk("proto_err", 64'(bus.proto_err), 64'(e[0]));
        chk("dqs_q0", 64'(bus.dqs_q0), 64'({NB{e[2]}}));
        chk("dqs_q1", 64'(bus.dqs_q1), 64'd0);
        if (bus.dq_oe) begin
          if (beats.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL beat_missing at %0t: got dq_oe=1 expected no beat pending", $time);
          end else begin
            b = beats.pop_front();
            chk("dq", 64'({bus.dq_q0, bus.dq_q1}), 64'(b[2*DW+DW/4-1:DW/4]));
            chk("dm", 64'({bus.dm_q0, bus.dm_q1}), 64'(b[DW/4-1:0]));
          end
        end else begin
          chk("dq_idle", 64'({bus.dq_q0, bus.dq_q1}), 64'd0);
          chk("dm_idle", 64'({bus.dm_q0, bus.dm_q1}), 64'd0);
        end
      end
    end
  end
  initial begin
    wait (&done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
